// File: rtl/nv_clkgate_en_ctrl_if.sv
// Request handshake, activity/config inputs and ICG drive outputs of the clock-gate controller.
// master = requester/unit side, slave = controller.
interface nv_clkgate_en_ctrl_if;
    logic        req_vld;
    logic        req_rdy;
    logic        unit_busy;
    logic        cfg_gate_dis;
    logic        test_mode;
    logic        gate_en;
    logic        gate_te;
    logic [1:0]  gate_state;
    logic [31:0] gate_off_cnt;

    modport master (
        output req_vld, unit_busy, cfg_gate_dis, test_mode,
        input  req_rdy, gate_en, gate_te, gate_state, gate_off_cnt
    );

    modport slave (
        input  req_vld, unit_busy, cfg_gate_dis, test_mode,
        output req_rdy, gate_en, gate_te, gate_state, gate_off_cnt
    );
endinterface

// File: rtl/nv_clkgate_en_ctrl.sv
// Enable controller for a latch-based ICG: closes the gate after an idle period,
// reopens it on activity and holds requests off until the gated domain settles.
module nv_clkgate_en_ctrl #(
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2,
    parameter int CNT_W    = 8
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    nv_clkgate_en_ctrl_if.slave  cg
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]  wake_cnt_q, wake_cnt_d;
    logic              gate_en_q;
    logic [31:0]       off_cnt_q;
    logic              act;

    assign act = cg.req_vld | cg.unit_busy | cg.cfg_gate_dis;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ST_OFF: begin
                if (act) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                // Wake always completes once started, even if the request goes away.
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = ST_ON;
                    idle_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + CNT_ONE;
                end
            end
            ST_ON: begin
                if (act) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_ONE;
                end
            end
            ST_DRAIN: begin
                if (act) begin
                    state_d    = ST_ON;
                    idle_cnt_d = '0;
                end else begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d    = ST_ON;
                idle_cnt_d = '0;
                wake_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q    <= ST_ON;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            gate_en_q  <= 1'b1;
            off_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            // Registered so E only moves on posedge, well clear of the ICG's negedge latch.
            gate_en_q  <= (state_d != ST_OFF);
            if (state_q == ST_OFF && off_cnt_q != 32'hFFFF_FFFF)
                off_cnt_q <= off_cnt_q + 32'd1;
        end
    end

    assign cg.req_rdy      = (state_q == ST_ON) & ~nvdla_core_rst;
    assign cg.gate_en      = gate_en_q;
    assign cg.gate_te      = cg.test_mode | cg.cfg_gate_dis;
    assign cg.gate_state   = state_q;
    assign cg.gate_off_cnt = off_cnt_q;

endmodule

// File: tb/tb_nv_clkgate_en_ctrl.sv
// Directed scenarios then random traffic, each cycle compared against a rule-level
// reference model of the gate controller.
module tb_nv_clkgate_en_ctrl;
    localparam int IDLE_CYC = 16;
    localparam int WAKE_CYC = 2;
    localparam int S_OFF = 0, S_WAKE = 1, S_ON = 2, S_DRAIN = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nv_clkgate_en_ctrl_if bus ();

    nv_clkgate_en_ctrl #(.IDLE_CYC(IDLE_CYC), .WAKE_CYC(WAKE_CYC), .CNT_W(8)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cg             (bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model: state name, quiet-cycle run, wake progress, OFF cycle tally
    int          m_st;
    int          m_quiet;
    int          m_wk;
    logic [31:0] m_off;
    bit          m_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit act;
        act = bus.req_vld | bus.unit_busy | bus.cfg_gate_dis;
        if (rst) begin
            m_st = S_ON; m_quiet = 0; m_wk = 0; m_off = 0; m_en = 1;
        end else begin
            if (m_st == S_OFF && m_off != 32'hFFFF_FFFF) m_off = m_off + 1;
            case (m_st)
                S_OFF:   if (act) begin m_st = S_WAKE; m_wk = 0; end
                S_WAKE:  if (m_wk == WAKE_CYC - 1) begin m_st = S_ON; m_quiet = 0; end
                         else m_wk++;
                S_ON:    if (act) m_quiet = 0;
                         else if (m_quiet == IDLE_CYC - 1) m_st = S_DRAIN;
                         else m_quiet++;
                default: begin m_st = act ? S_ON : S_OFF; m_quiet = 0; end
            endcase
            m_en = (m_st != S_OFF);
        end
    endtask

    task automatic check_model();
        chk("m_state",   32'(bus.gate_state), 32'(m_st));
        chk("m_gate_en", 32'(bus.gate_en),    32'(m_en));
        chk("m_req_rdy", 32'(bus.req_rdy),    32'((m_st == S_ON) && !rst));
        chk("m_gate_te", 32'(bus.gate_te),    32'(bus.test_mode | bus.cfg_gate_dis));
        chk("m_off_cnt", bus.gate_off_cnt,    m_off);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        bus.req_vld = 0; bus.unit_busy = 0; bus.cfg_gate_dis = 0; bus.test_mode = 0;
    endtask

    logic [31:0] frozen;

    initial begin
        idle_inputs();
        m_st = S_ON; m_quiet = 0; m_wk = 0; m_off = 0; m_en = 1;

        // 1. reset then idle close
        repeat (4) tick();
        chk("rst_rdy0", 32'(bus.req_rdy), 0);
        chk("rst_state", 32'(bus.gate_state), S_ON);
        chk("rst_gate_en", 32'(bus.gate_en), 1);
        rst = 0;
        tick();
        chk("post_rst_rdy", 32'(bus.req_rdy), 1);
        repeat (15) tick();
        chk("t1_drain", 32'(bus.gate_state), S_DRAIN);
        chk("t1_drain_en", 32'(bus.gate_en), 1);
        tick();
        chk("t1_off", 32'(bus.gate_state), S_OFF);
        chk("t1_en0", 32'(bus.gate_en), 0);
        chk("t1_cnt0", bus.gate_off_cnt, 0);
        tick(); chk("t1_cnt1", bus.gate_off_cnt, 1);
        tick(); chk("t1_cnt2", bus.gate_off_cnt, 2);

        // 2. wake latency
        bus.req_vld = 1;
        tick();
        chk("t2_en_t1", 32'(bus.gate_en), 1);
        chk("t2_wake_t1", 32'(bus.gate_state), S_WAKE);
        chk("t2_rdy_t1", 32'(bus.req_rdy), 0);
        tick();
        chk("t2_wake_t2", 32'(bus.gate_state), S_WAKE);
        tick();
        chk("t2_on_t3", 32'(bus.gate_state), S_ON);
        chk("t2_rdy_t3", 32'(bus.req_rdy), 1);
        bus.req_vld = 0;

        // 3. busy pulse at idle_cnt==15 restarts the idle period
        repeat (15) tick();
        chk("t3_idle15", 32'(dut.idle_cnt_q), 15);
        bus.unit_busy = 1;
        tick();
        bus.unit_busy = 0;
        chk("t3_idle0", 32'(dut.idle_cnt_q), 0);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t3_stay_on", 32'(bus.gate_state), S_ON);
        end
        tick();
        chk("t3_drain", 32'(bus.gate_state), S_DRAIN);

        // 4. request during DRAIN returns straight to ON
        bus.req_vld = 1;
        tick();
        chk("t4_on", 32'(bus.gate_state), S_ON);
        chk("t4_en", 32'(bus.gate_en), 1);
        chk("t4_rdy", 32'(bus.req_rdy), 1);
        bus.req_vld = 0;

        // 5. gating disabled, then test_mode only
        frozen = bus.gate_off_cnt;
        bus.cfg_gate_dis = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("t5_en", 32'(bus.gate_en), 1);
            chk("t5_te", 32'(bus.gate_te), 1);
        end
        chk("t5_frozen", bus.gate_off_cnt, frozen);
        bus.cfg_gate_dis = 0;
        bus.test_mode = 1;
        repeat (17) tick();
        chk("t5_tm_off", 32'(bus.gate_state), S_OFF);
        chk("t5_tm_te", 32'(bus.gate_te), 1);
        bus.test_mode = 0;

        // 6. reset mid-WAKE, reset mid-OFF, saturation
        bus.req_vld = 1;
        tick();
        chk("t6_in_wake", 32'(bus.gate_state), S_WAKE);
        rst = 1;
        tick();
        chk("t6w_state", 32'(bus.gate_state), S_ON);
        chk("t6w_en", 32'(bus.gate_en), 1);
        chk("t6w_wake", 32'(dut.wake_cnt_q), 0);
        chk("t6w_idle", 32'(dut.idle_cnt_q), 0);
        chk("t6w_off", bus.gate_off_cnt, 0);
        rst = 0; bus.req_vld = 0;
        repeat (20) tick();
        chk("t6_in_off", 32'(bus.gate_state), S_OFF);
        rst = 1;
        tick();
        chk("t6o_state", 32'(bus.gate_state), S_ON);
        chk("t6o_off", bus.gate_off_cnt, 0);
        rst = 0;
        repeat (18) tick();
        force dut.off_cnt_q = 32'hFFFF_FFFE;
        m_off = 32'hFFFF_FFFE;
        #1 release dut.off_cnt_q;
        tick();
        chk("t6_sat", bus.gate_off_cnt, 32'hFFFF_FFFF);
        repeat (3) tick();
        chk("t6_hold", bus.gate_off_cnt, 32'hFFFF_FFFF);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            rst              = ($urandom_range(0, 99) == 0);
            bus.req_vld      = ($urandom_range(0, 19) == 0) || (bus.req_vld && !bus.req_rdy);
            bus.unit_busy    = ($urandom_range(0, 15) == 0);
            bus.cfg_gate_dis = ($urandom_range(0, 49) == 0);
            bus.test_mode    = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
